// File: rtl/ps2_key_serializer_pkg.sv
// -----------------------------------------------------------------------------
// ps2_ser_pkg
// Shared definitions for the PS/2 key serializer:
//   - PS2_E0 / PS2_F0 : extended-prefix and break-prefix scan bytes
//   - LAST_BIT        : index of the stop bit within an 11-bit frame
//   - ser_state_t     : serializer state encoding
//   - calc_half()     : clk_sys cycles per half PS/2 bit (integer floor)
//   - odd_parity()    : PS/2 parity bit for a data byte
// -----------------------------------------------------------------------------
package ps2_ser_pkg;

    localparam logic [7:0] PS2_E0   = 8'hE0;
    localparam logic [7:0] PS2_F0   = 8'hF0;
    localparam logic [3:0] LAST_BIT = 4'd10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BIT_HI = 2'd1,
        BIT_LO = 2'd2,
        GAP    = 2'd3
    } ser_state_t;

    function automatic int calc_half(input int clk_hz, input int ps2_hz);
        return clk_hz / (2 * ps2_hz);
    endfunction

    // Parity bit that makes the total count of ones over data+parity odd.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_key_serializer_if.sv
// -----------------------------------------------------------------------------
// ps2_key_serializer_if
// Bundles the event word from hps_io and the device-side PS/2 lines.
//   ps2_key[10:0] : event word (toggle, press, extended, scan code)
//   ps2_clk       : PS/2 clock, idles high
//   ps2_data      : PS/2 data, idles high
//   busy          : FIFO non-empty or serializer active
//   overflow      : one-cycle pulse when an event is dropped
// Modports: master = event source / line observer, slave = serializer.
// -----------------------------------------------------------------------------
interface ps2_key_serializer_if;

    logic [10:0] ps2_key;
    logic        ps2_clk;
    logic        ps2_data;
    logic        busy;
    logic        overflow;

    modport master (
        output ps2_key,
        input  ps2_clk,
        input  ps2_data,
        input  busy,
        input  overflow
    );

    modport slave (
        input  ps2_key,
        output ps2_clk,
        output ps2_data,
        output busy,
        output overflow
    );

endinterface

// File: rtl/ps2_key_serializer_fifo.sv
// -----------------------------------------------------------------------------
// ps2_byte_fifo
// Synchronous byte FIFO with first-word-fall-through read data.
//   clk_sys     : clock
//   reset       : asynchronous active-high reset (empties the FIFO)
//   i_push      : write i_push_data this cycle
//   i_push_data : byte to write
//   i_pop       : consume the byte currently on o_rd_data
//   o_rd_data   : oldest stored byte (valid while o_empty is 0)
//   o_count     : number of stored bytes
//   o_empty     : FIFO holds no bytes
// DEPTH must be a power of two (pointers wrap naturally) and at least 4.
// -----------------------------------------------------------------------------
module ps2_byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk_sys,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic [7:0]               i_push_data,
    input  logic                     i_pop,
    output logic [7:0]               o_rd_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    // Guard against misuse so pointers and count can never disagree.
    assign w_do_push = i_push && (r_count != FULL_COUNT);
    assign w_do_pop  = i_pop && (r_count != {(AW + 1){1'b0}});

    // Storage array: plain registers, contents are don't-care after reset.
    always_ff @(posedge clk_sys) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointers and occupancy count.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {(AW + 1){1'b0}};
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW + 1)'(1);
                2'b01:   r_count <= r_count - (AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_count   = r_count;
    assign o_empty   = (r_count == {(AW + 1){1'b0}});

endmodule

// File: rtl/ps2_key_serializer.sv
// -----------------------------------------------------------------------------
// ps2_key_serializer
// Turns hps_io key events into a PS/2 device-side serial stream.
//   clk_sys : system clock (only clock)
//   reset   : asynchronous active-high reset; aborts any frame, lines go high
//   bus     : slave modport of ps2_key_serializer_if
//             (ps2_key in; ps2_clk, ps2_data, busy, overflow out)
// Parameters: CLK_HZ, PS2_HZ set the bit rate (HALF = CLK_HZ/(2*PS2_HZ));
//             FIFO_DEPTH is the byte buffer depth (power of two, >= 4).
// An event becomes [E0 if ext][F0 if release] code; the whole list is queued
// or the whole event is dropped with an overflow pulse.
// -----------------------------------------------------------------------------
module ps2_key_serializer
    import ps2_ser_pkg::*;
#(
    parameter int CLK_HZ     = 28_636_360,
    parameter int PS2_HZ     = 12_500,
    parameter int FIFO_DEPTH = 16
) (
    input  logic clk_sys,
    input  logic reset,
    ps2_key_serializer_if.slave bus
);

    localparam int HALF = calc_half(CLK_HZ, PS2_HZ);
    localparam int CW   = $clog2(4 * HALF) + 1;
    localparam int AW   = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
    // The IDLE cycle that pops the next byte completes the 4*HALF high gap,
    // so GAP itself runs one cycle short; start-to-start is exactly 26*HALF.
    localparam logic [CW-1:0] GAP_LAST  = CW'(4 * HALF - 2);
    localparam logic [AW:0]   DEPTH_V   = (AW + 1)'(FIFO_DEPTH);

    // ---------------- event detection / encoder ----------------
    logic        r_primed;
    logic        r_last_tog;
    logic [23:0] r_enc_buf;     // pending bytes, next byte in [23:16]
    logic [1:0]  r_enc_cnt;     // bytes still to push; non-zero = encoder busy
    logic        r_overflow;

    logic [23:0] w_list;
    logic [1:0]  w_nbytes;
    logic        w_event;
    logic [AW:0] w_free;
    logic        w_fits;
    logic        w_push;
    logic [7:0]  w_push_data;

    // ---------------- FIFO ----------------
    logic        w_pop;
    logic [7:0]  w_rd_data;
    logic [AW:0] w_count;
    logic        w_empty;

    // ---------------- serializer ----------------
    ser_state_t  r_state;
    ser_state_t  w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [3:0]  r_bitcnt;
    logic [3:0]  w_bitcnt_nxt;
    logic [10:0] r_shift;
    logic [10:0] w_shift_nxt;
    logic        r_ps2_clk;
    logic        r_ps2_data;
    logic        r_busy;
    logic        w_clk_nxt;
    logic        w_data_nxt;

    // A new event is only taken once the previous one is fully pushed.
    assign w_event = r_primed && (bus.ps2_key[10] != r_last_tog) && (r_enc_cnt == 2'd0);
    // Free space uses the count before any same-cycle pop.
    assign w_free  = DEPTH_V - w_count;
    assign w_fits  = (w_free >= {{(AW - 1){1'b0}}, w_nbytes});

    // Byte list for the current event word, left-aligned.
    always_comb begin
        w_list   = {bus.ps2_key[7:0], 16'h0000};
        w_nbytes = 2'd1;
        case ({bus.ps2_key[8], ~bus.ps2_key[9]})
            2'b11: begin
                w_list   = {PS2_E0, PS2_F0, bus.ps2_key[7:0]};
                w_nbytes = 2'd3;
            end
            2'b10: begin
                w_list   = {PS2_E0, bus.ps2_key[7:0], 8'h00};
                w_nbytes = 2'd2;
            end
            2'b01: begin
                w_list   = {PS2_F0, bus.ps2_key[7:0], 8'h00};
                w_nbytes = 2'd2;
            end
            default: begin
                w_list   = {bus.ps2_key[7:0], 16'h0000};
                w_nbytes = 2'd1;
            end
        endcase
    end

    // Event acceptance, whole-event drop and one-byte-per-cycle pushing.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_primed   <= 1'b0;
            r_last_tog <= 1'b0;
            r_enc_buf  <= 24'h000000;
            r_enc_cnt  <= 2'd0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= 1'b0;
            if (!r_primed) begin
                // Adopt whatever toggle level is present; it is not an event.
                r_primed   <= 1'b1;
                r_last_tog <= bus.ps2_key[10];
            end else if (w_event) begin
                r_last_tog <= bus.ps2_key[10];
                if (w_fits) begin
                    r_enc_buf <= w_list;
                    r_enc_cnt <= w_nbytes;
                end else begin
                    r_overflow <= 1'b1;
                end
            end else if (r_enc_cnt != 2'd0) begin
                r_enc_buf <= {r_enc_buf[15:0], 8'h00};
                r_enc_cnt <= r_enc_cnt - 2'd1;
            end else begin
                r_enc_buf <= r_enc_buf;
            end
        end
    end

    assign w_push      = (r_enc_cnt != 2'd0);
    assign w_push_data = r_enc_buf[23:16];

    ps2_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_rd_data   (w_rd_data),
        .o_count     (w_count),
        .o_empty     (w_empty)
    );

    // Serializer state register.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_cnt    <= {CW{1'b0}};
            r_bitcnt <= 4'd0;
            r_shift  <= 11'h7FF;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_bitcnt <= w_bitcnt_nxt;
            r_shift  <= w_shift_nxt;
        end
    end

    // Serializer next-state logic: pop, bit timing, frame sequencing.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_bitcnt_nxt = r_bitcnt;
        w_shift_nxt  = r_shift;
        w_pop        = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    // Frame LSB first: start 0, d[7:0], parity, stop 1.
                    w_shift_nxt  = {1'b1, odd_parity(w_rd_data), w_rd_data, 1'b0};
                    w_bitcnt_nxt = 4'd0;
                    w_cnt_nxt    = {CW{1'b0}};
                    w_state_nxt  = BIT_HI;
                end else begin
                    w_state_nxt  = IDLE;
                end
            end
            BIT_HI: begin
                if (r_cnt == HALF_LAST) begin
                    w_cnt_nxt   = {CW{1'b0}};
                    w_state_nxt = BIT_LO;
                end else begin
                    w_cnt_nxt   = r_cnt + CW'(1);
                end
            end
            BIT_LO: begin
                if (r_cnt == HALF_LAST) begin
                    w_cnt_nxt = {CW{1'b0}};
                    if (r_bitcnt == LAST_BIT) begin
                        w_state_nxt = GAP;
                    end else begin
                        w_bitcnt_nxt = r_bitcnt + 4'd1;
                        w_shift_nxt  = {1'b1, r_shift[10:1]};
                        w_state_nxt  = BIT_HI;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            GAP: begin
                if (r_cnt == GAP_LAST) begin
                    w_cnt_nxt   = {CW{1'b0}};
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt   = r_cnt + CW'(1);
                end
            end
            default: begin
                w_cnt_nxt   = {CW{1'b0}};
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Line levels are derived from the next state so the registered outputs
    // line up with the state they belong to.
    always_comb begin
        w_clk_nxt  = 1'b1;
        w_data_nxt = 1'b1;
        case (w_state_nxt)
            BIT_HI: begin
                w_clk_nxt  = 1'b1;
                w_data_nxt = w_shift_nxt[0];
            end
            BIT_LO: begin
                w_clk_nxt  = 1'b0;
                w_data_nxt = w_shift_nxt[0];
            end
            default: begin
                w_clk_nxt  = 1'b1;
                w_data_nxt = 1'b1;
            end
        endcase
    end

    // Registered line and status outputs.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_ps2_clk  <= 1'b1;
            r_ps2_data <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            r_ps2_clk  <= w_clk_nxt;
            r_ps2_data <= w_data_nxt;
            r_busy     <= !w_empty || (r_state != IDLE);
        end
    end

    assign bus.ps2_clk  = r_ps2_clk;
    assign bus.ps2_data = r_ps2_data;
    assign bus.busy     = r_busy;
    assign bus.overflow = r_overflow;

endmodule
